// File: rtl/tdm_demux16_if.sv
// Bus between the TDM serial source and the tdm_demux16 receiver.
// The source drives the slot strobe and serial bit; the receiver returns the frame and slot status.
interface tdm_demux16_if #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
);
    logic             en;
    logic             frame_start;
    logic             din;
    logic [0:WIDTH-1] dout;
    logic             valid;
    logic [0:SEL_W-1] sel;
    logic             busy;
    logic             sync_err;

    modport master (
        output en, frame_start, din,
        input  dout, valid, sel, busy, sync_err
    );

    modport slave (
        input  en, frame_start, din,
        output dout, valid, sel, busy, sync_err
    );
endinterface

// File: rtl/tdm_demux16.sv
// Receive side of the 16:1 TDM link: steers one serial bit per strobe into its slot
// and presents each completed frame in parallel with a one-cycle valid pulse.
module tdm_demux16 #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input logic          clk,
    input logic          reset,
    tdm_demux16_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] ONE       = SEL_W'(1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] slot_q, slot_d;
    logic [0:WIDTH-1] buf_q, buf_d;
    logic [0:WIDTH-1] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             sync_err_q, sync_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            buf_q      <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            buf_q      <= buf_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            sync_err_q <= sync_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        buf_d      = buf_q;
        dout_d     = dout_q;
        valid_d    = 1'b0;
        sync_err_d = 1'b0;
        if (bus.en) begin
            case (state_q)
                IDLE: begin
                    // Bits arriving before any frame marker carry no slot alignment and are dropped.
                    if (bus.frame_start) begin
                        buf_d[0] = bus.din;
                        slot_d   = ONE;
                        state_d  = RECV;
                    end
                end
                RECV: begin
                    if (bus.frame_start) begin
                        // Realign on the new marker; stale bits above slot 0 are overwritten before use.
                        sync_err_d = 1'b1;
                        buf_d[0]   = bus.din;
                        slot_d     = ONE;
                    end else if (slot_q == LAST_SLOT) begin
                        dout_d          = buf_q;
                        dout_d[WIDTH-1] = bus.din;
                        valid_d         = 1'b1;
                        slot_d          = '0;
                        state_d         = IDLE;
                    end else begin
                        buf_d[slot_q] = bus.din;
                        slot_d        = slot_q + ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.dout     = dout_q;
    assign bus.valid    = valid_q;
    assign bus.sel      = (state_q == RECV) ? slot_q : '0;
    assign bus.busy     = (state_q == RECV);
    assign bus.sync_err = sync_err_q;
endmodule
